// File: rtl/mips_multicycle_ctrl.sv
// mips_multicycle_ctrl: main control FSM for the multicycle MIPS datapath.
// Ports:
//   clk, reset      - rising-edge clock, synchronous active-high reset
//   Op[5:0]         - instruction opcode (IR[31:26]), sampled in DECODE
//   mem_ready       - memory completed the current access this cycle
//   PCWrite, PCWriteCond, BranchNe, IorD, MemRead, MemWrite, MemtoReg,
//   IRWrite, ALUSrcA, RegWrite, RegDst - datapath enables / selects
//   PCSource[1:0], ALUSrcB[1:0], ALUOp[1:0] - datapath mux selects / ALU op class
//   illegal_op      - pulses in DECODE on an unsupported opcode
//   state[3:0]      - current state, for debug
module mips_multicycle_ctrl (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] Op,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       BranchNe,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       MemtoReg,
    output logic       IRWrite,
    output logic       ALUSrcA,
    output logic       RegWrite,
    output logic       RegDst,
    output logic [1:0] PCSource,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic       illegal_op,
    output logic [3:0] state
);
    typedef enum logic [3:0] {
        FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMREAD = 4'd3,
        MEMWB = 4'd4, MEMWRITE = 4'd5, EXECUTE = 4'd6, ALUWB = 4'd7,
        BRANCH = 4'd8, JUMP = 4'd9, ADDIEX = 4'd10, ADDIWB = 4'd11
    } state_t;

    localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011,
                           OP_BEQ = 6'b000100, OP_BNE = 6'b000101, OP_J = 6'b000010,
                           OP_ADDI = 6'b001000;

    state_t st, nxt;
    logic [5:0] op_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            st   <= FETCH;
            op_q <= '0;
        end else begin
            st <= nxt;
            if (st == DECODE) op_q <= Op;
        end
    end

    always_comb begin
        nxt         = st;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        BranchNe    = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        MemtoReg    = 1'b0;
        IRWrite     = 1'b0;
        ALUSrcA     = 1'b0;
        RegWrite    = 1'b0;
        RegDst      = 1'b0;
        PCSource    = 2'b00;
        ALUSrcB     = 2'b00;
        ALUOp       = 2'b00;
        illegal_op  = 1'b0;
        case (st)
            FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                IRWrite = mem_ready;
                PCWrite = mem_ready;
                nxt     = mem_ready ? DECODE : FETCH;
            end
            DECODE: begin
                ALUSrcB = 2'b11;
                case (Op)
                    OP_LW, OP_SW:    nxt = MEMADR;
                    OP_R:            nxt = EXECUTE;
                    OP_BEQ, OP_BNE:  nxt = BRANCH;
                    OP_J:            nxt = JUMP;
                    OP_ADDI:         nxt = ADDIEX;
                    default: begin
                        nxt        = FETCH;
                        illegal_op = 1'b1;
                    end
                endcase
            end
            MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                nxt     = (op_q == OP_LW) ? MEMREAD : MEMWRITE;
            end
            MEMREAD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
                nxt     = mem_ready ? MEMWB : MEMREAD;
            end
            MEMWB: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
                nxt      = FETCH;
            end
            MEMWRITE: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
                nxt      = mem_ready ? FETCH : MEMWRITE;
            end
            EXECUTE: begin
                ALUSrcA = 1'b1;
                ALUOp   = 2'b10;
                nxt     = ALUWB;
            end
            ALUWB: begin
                RegWrite = 1'b1;
                RegDst   = 1'b1;
                nxt      = FETCH;
            end
            BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUOp       = 2'b01;
                PCWriteCond = 1'b1;
                PCSource    = 2'b01;
                BranchNe    = (op_q == OP_BNE);
                nxt         = FETCH;
            end
            JUMP: begin
                PCWrite  = 1'b1;
                PCSource = 2'b10;
                nxt      = FETCH;
            end
            ADDIEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                nxt     = ADDIWB;
            end
            ADDIWB: begin
                RegWrite = 1'b1;
                nxt      = FETCH;
            end
            default: nxt = FETCH;
        endcase
        // Reset is synchronous, so the state may still be mid-instruction in the
        // reset cycle; suppress every write so the aborted instruction has no effect.
        if (reset) begin
            PCWrite     = 1'b0;
            PCWriteCond = 1'b0;
            IRWrite     = 1'b0;
            MemWrite    = 1'b0;
            RegWrite    = 1'b0;
            illegal_op  = 1'b0;
        end
    end

    assign state = st;
endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// tb_mips_multicycle_ctrl: directed self-checking bench for mips_multicycle_ctrl.
module tb_mips_multicycle_ctrl;
    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] Op;
    logic       mem_ready;
    logic       PCWrite, PCWriteCond, BranchNe, IorD, MemRead, MemWrite, MemtoReg;
    logic       IRWrite, ALUSrcA, RegWrite, RegDst, illegal_op;
    logic [1:0] PCSource, ALUSrcB, ALUOp;
    logic [3:0] state;
    int total = 0;
    int bad = 0;

    mips_multicycle_ctrl dut (
        .clk(clk), .reset(reset), .Op(Op), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .BranchNe(BranchNe),
        .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg),
        .IRWrite(IRWrite), .ALUSrcA(ALUSrcA), .RegWrite(RegWrite), .RegDst(RegDst),
        .PCSource(PCSource), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
        .illegal_op(illegal_op), .state(state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic cyc(input logic rdy, input logic [3:0] es, input string tag);
        @(posedge clk);
        #1 mem_ready = rdy;
        #1 chk(tag, 8'(state), 8'(es));
    endtask

    initial begin
        reset = 1'b1; Op = 6'b000000; mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 chk("rst_state", 8'(state), 8'd0);
        mem_ready = 1'b1;
        #1 chk("rst_irwrite", 8'(IRWrite), 8'd0);
        chk("rst_pcwrite", 8'(PCWrite), 8'd0);
        reset = 1'b0;
        #1 chk("first_fetch", 8'(state), 8'd0);
        chk("fetch_irwrite", 8'(IRWrite), 8'd1);
        // R-type
        cyc(1, 1, "r_dec");
        chk("dec_alusrcb", 8'(ALUSrcB), 8'd3);
        cyc(1, 6, "r_exe");
        chk("r_aluop", 8'(ALUOp), 8'd2);
        chk("r_exe_regwr", 8'(RegWrite), 8'd0);
        cyc(1, 7, "r_wb");
        chk("r_wb_regwr", 8'(RegWrite), 8'd1);
        chk("r_wb_regdst", 8'(RegDst), 8'd1);
        Op = 6'b100011;
        cyc(1, 0, "r_end");
        chk("r_end_regwr", 8'(RegWrite), 8'd0);
        // lw with two MEMREAD stall cycles
        cyc(1, 1, "lw_dec");
        cyc(1, 2, "lw_adr");
        chk("lw_adr_srca", 8'(ALUSrcA), 8'd1);
        chk("lw_adr_srcb", 8'(ALUSrcB), 8'd2);
        for (int i = 0; i < 3; i++) begin
            cyc(i == 2, 3, "lw_rd");
            chk("lw_rd_memread", 8'(MemRead), 8'd1);
            chk("lw_rd_iord", 8'(IorD), 8'd1);
        end
        cyc(1, 4, "lw_wb");
        chk("lw_wb_regwr", 8'(RegWrite), 8'd1);
        chk("lw_wb_memtoreg", 8'(MemtoReg), 8'd1);
        chk("lw_wb_regdst", 8'(RegDst), 8'd0);
        Op = 6'b101011;
        // sw with one FETCH stall cycle; Op is changed to lw after DECODE
        cyc(0, 0, "sw_f0");
        chk("sw_f0_irwrite", 8'(IRWrite), 8'd0);
        chk("sw_f0_pcwrite", 8'(PCWrite), 8'd0);
        chk("sw_f0_memread", 8'(MemRead), 8'd1);
        cyc(1, 0, "sw_f1");
        chk("sw_f1_irwrite", 8'(IRWrite), 8'd1);
        chk("sw_f1_pcwrite", 8'(PCWrite), 8'd1);
        cyc(1, 1, "sw_dec");
        cyc(1, 2, "sw_adr");
        Op = 6'b100011;
        cyc(1, 5, "sw_wr");
        chk("sw_memwrite", 8'(MemWrite), 8'd1);
        chk("sw_iord", 8'(IorD), 8'd1);
        Op = 6'b000100;
        cyc(1, 0, "sw_end");
        // beq then bne
        for (int b = 0; b < 2; b++) begin
            cyc(1, 1, "br_dec");
            cyc(1, 8, "br_st");
            chk("br_aluop", 8'(ALUOp), 8'd1);
            chk("br_pcwrcond", 8'(PCWriteCond), 8'd1);
            chk("br_pcsrc", 8'(PCSource), 8'd1);
            chk("br_ne", 8'(BranchNe), 8'(b));
            Op = (b == 0) ? 6'b000101 : 6'b000010;
            cyc(1, 0, "br_end");
        end
        // j
        cyc(1, 1, "j_dec");
        cyc(1, 9, "j_st");
        chk("j_pcwrite", 8'(PCWrite), 8'd1);
        chk("j_pcsrc", 8'(PCSource), 8'd2);
        Op = 6'b001000;
        cyc(1, 0, "j_end");
        // addi
        cyc(1, 1, "addi_dec");
        cyc(1, 10, "addi_ex");
        chk("addi_srcb", 8'(ALUSrcB), 8'd2);
        chk("addi_aluop", 8'(ALUOp), 8'd0);
        chk("addi_srca", 8'(ALUSrcA), 8'd1);
        cyc(1, 11, "addi_wb");
        chk("addi_regwr", 8'(RegWrite), 8'd1);
        chk("addi_regdst", 8'(RegDst), 8'd0);
        Op = 6'b111111;
        cyc(1, 0, "addi_end");
        chk("pre_ill", 8'(illegal_op), 8'd0);
        // illegal opcode
        cyc(1, 1, "ill_dec");
        chk("ill_pulse", 8'(illegal_op), 8'd1);
        cyc(1, 0, "ill_end");
        chk("ill_clear", 8'(illegal_op), 8'd0);
        Op = 6'b101011;
        // reset during a MEMWRITE stall
        cyc(1, 1, "rs_dec");
        cyc(1, 2, "rs_adr");
        cyc(0, 5, "rs_wr0");
        chk("rs_memwrite", 8'(MemWrite), 8'd1);
        cyc(0, 5, "rs_wr1");
        reset = 1'b1;
        #1 chk("rs_memwrite_rst", 8'(MemWrite), 8'd0);
        @(posedge clk);
        #1 chk("rs_state", 8'(state), 8'd0);
        reset = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
